// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch stage for the 16-bit CPU.
// Owns the program counter, issues reads to a synchronous instruction memory
// (data returns one cycle after the request), buffers returned words in a
// 2-entry prefetch queue and hands them downstream over valid/ready.
// Supports jump (queue flush and redirect) and halt (stop issuing new fetches).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_addr    fetch address (equals pc), meaningful when imem_rd=1
//   imem_rd      fetch request (combinational)
//   imem_data    memory word for the request issued one cycle earlier
//   instr        head of the prefetch queue (stale when instr_valid=0)
//   instr_valid  prefetch queue non-empty
//   instr_ready  downstream accepts instr this cycle
//   jump         single-cycle redirect pulse
//   jump_addr    redirect target
//   halt         level; no new fetches while high
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic [DATA_W-1:0] imem_data,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt
);

  localparam int unsigned DEPTH = 2;
  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] fifo_q [DEPTH];
  logic [DATA_W-1:0] fifo_d [DEPTH];
  logic              head_q, head_d;
  logic [1:0]        count_q, count_d;
  logic              inflight_q, inflight_d;
  logic              kill_q, kill_d;

  logic              pop;
  logic              push;
  logic              redirect;
  logic              issue;
  logic [2:0]        occupancy;
  logic [2:0]        limit;

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_ADDR;
      head_q     <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      head_q     <= head_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // Next-state, queue update and fetch issue
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    head_d     = head_q;
    count_d    = count_q;
    inflight_d = 1'b0;
    kill_d     = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fifo_d[i] = fifo_q[i];
    end

    redirect = jump && (state_q != ST_BOOT);
    pop      = (count_q != 2'd0) && instr_ready && !jump;
    // A response landing in the jump cycle is dropped by the flush itself.
    push     = inflight_q && !kill_q && !redirect;

    // Room for another request: count + inflight < 2 + pop
    occupancy = 3'(count_q) + 3'(inflight_q);
    limit     = 3'd2 + 3'(pop);
    issue     = (state_q == ST_RUN) && !halt && !jump && (occupancy < limit);

    imem_rd   = issue;
    imem_addr = pc_q;

    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  if (halt)  state_d = ST_HALT;
      ST_HALT: if (!halt) state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase

    if (issue) begin
      pc_d       = pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
    end

    if (redirect) begin
      count_d = 2'd0;
      pc_d    = jump_addr;
      kill_d  = inflight_q;
    end else begin
      // Tail slot is head + count; when full, push only happens with pop,
      // so the slot being vacated by the head receives the new tail word.
      if (push) begin
        fifo_d[head_q ^ count_q[0]] = imem_data;
      end
      if (pop) begin
        head_d = ~head_q;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  assign instr       = fifo_q[head_q];
  assign instr_valid = (count_q != 2'd0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: a directed per-cycle vector table covering
// boot, backpressure, jump flush and halt, hand sequences for PC wrap and
// mid-run reset, then randomized stimulus against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic          imem_rd;
  logic [DW-1:0] imem_data = '0;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          jump;
  logic [AW-1:0] jump_addr;
  logic          halt;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_addr  (imem_addr),
    .imem_rd    (imem_rd),
    .imem_data  (imem_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .halt       (halt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Synchronous instruction memory: word for the request appears next cycle
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem_word(imem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          ready;
    logic          hlt;
    logic          jmp;
    logic [AW-1:0] jaddr;
    logic          rd;
    logic [AW-1:0] addr;
    logic          valid;
    logic [DW-1:0] ins;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h, input logic j, input logic [7:0] ja,
                              input logic rd, input logic [7:0] a, input logic v,
                              input logic [15:0] i);
    vec_t t;
    t.ready = r; t.hlt = h; t.jmp = j; t.jaddr = ja;
    t.rd = rd; t.addr = a; t.valid = v; t.ins = i;
    return t;
  endfunction

  vec_t tbl [28];

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    instr_ready = 1'b1; jump = 1'b0; jump_addr = '0; halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [31:0] qa[$];
    logic [31:0] qi[$];
    logic [31:0] exp_a [3];
    logic [31:0] exp_i [3];
    // reference model state
    int            m_state;
    int            m_pc;
    logic [DW-1:0] m_q[$];
    bit            m_pend;
    int            m_pend_addr;
    bit            e_valid, e_rd, e_pop;
    int            room;

    // Boot, backpressure, jump flush, halt, jump during halt
    tbl[0]  = mk(1,0,0,8'h00, 0,8'h00,0,16'h0000);
    tbl[1]  = mk(1,0,0,8'h00, 1,8'h00,0,16'h0000);
    tbl[2]  = mk(1,0,0,8'h00, 1,8'h01,0,16'h0000);
    tbl[3]  = mk(1,0,0,8'h00, 1,8'h02,1,16'h1000);
    tbl[4]  = mk(1,0,0,8'h00, 1,8'h03,1,16'h1001);
    tbl[5]  = mk(0,0,0,8'h00, 0,8'h04,1,16'h1002);
    tbl[6]  = mk(0,0,0,8'h00, 0,8'h04,1,16'h1002);
    tbl[7]  = mk(1,0,0,8'h00, 1,8'h04,1,16'h1002);
    tbl[8]  = mk(0,0,0,8'h00, 0,8'h05,1,16'h1003);
    tbl[9]  = mk(1,0,0,8'h00, 1,8'h05,1,16'h1003);
    tbl[10] = mk(1,0,1,8'h40, 0,8'h06,1,16'h1004);
    tbl[11] = mk(1,0,0,8'h00, 1,8'h40,0,16'h0000);
    tbl[12] = mk(1,0,0,8'h00, 1,8'h41,0,16'h0000);
    tbl[13] = mk(1,0,0,8'h00, 1,8'h42,1,16'h1040);
    tbl[14] = mk(1,1,0,8'h00, 0,8'h43,1,16'h1041);
    tbl[15] = mk(1,1,0,8'h00, 0,8'h43,1,16'h1042);
    tbl[16] = mk(1,1,0,8'h00, 0,8'h43,0,16'h0000);
    tbl[17] = mk(1,0,0,8'h00, 0,8'h43,0,16'h0000);
    tbl[18] = mk(1,0,0,8'h00, 1,8'h43,0,16'h0000);
    tbl[19] = mk(1,0,0,8'h00, 1,8'h44,0,16'h0000);
    tbl[20] = mk(1,0,0,8'h00, 1,8'h45,1,16'h1043);
    tbl[21] = mk(1,1,0,8'h00, 0,8'h46,1,16'h1044);
    tbl[22] = mk(1,1,1,8'h80, 0,8'h46,1,16'h1045);
    tbl[23] = mk(1,1,0,8'h00, 0,8'h80,0,16'h0000);
    tbl[24] = mk(1,0,0,8'h00, 0,8'h80,0,16'h0000);
    tbl[25] = mk(1,0,0,8'h00, 1,8'h80,0,16'h0000);
    tbl[26] = mk(1,0,0,8'h00, 1,8'h81,0,16'h0000);
    tbl[27] = mk(1,0,0,8'h00, 1,8'h82,1,16'h1080);

    rst = 1'b0;
    instr_ready = 1'b1; jump = 1'b0; jump_addr = '0; halt = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_valid", 32'(instr_valid), 32'd0);
    chk("reset_rd",    32'(imem_rd),     32'd0);
    chk("reset_addr",  32'(imem_addr),   32'd0);
    chk("reset_instr", 32'(instr),       32'd0);
    rst = 1'b1;

    for (int i = 0; i < 28; i++) begin
      instr_ready = tbl[i].ready;
      halt        = tbl[i].hlt;
      jump        = tbl[i].jmp;
      jump_addr   = tbl[i].jaddr;
      #1;
      chk($sformatf("vec%0d_rd", i),    32'(imem_rd),     32'(tbl[i].rd));
      chk($sformatf("vec%0d_addr", i),  32'(imem_addr),   32'(tbl[i].addr));
      chk($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) chk($sformatf("vec%0d_instr", i), 32'(instr), 32'(tbl[i].ins));
      @(posedge clk);
      @(negedge clk);
    end

    // PC wrap: jump to 0xFE with ready held high
    instr_ready = 1'b1; halt = 1'b0; jump = 1'b1; jump_addr = 8'hFE;
    @(posedge clk);
    @(negedge clk);
    jump = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (imem_rd) qa.push_back(32'(imem_addr));
      if (instr_valid && instr_ready) qi.push_back(32'(instr));
      @(posedge clk);
      @(negedge clk);
    end
    exp_a[0] = 32'h00FE; exp_a[1] = 32'h00FF; exp_a[2] = 32'h0000;
    exp_i[0] = 32'h10FE; exp_i[1] = 32'h10FF; exp_i[2] = 32'h1000;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wrap_addr%0d", i), (i < qa.size()) ? qa[i] : 32'hFFFF_FFFF, exp_a[i]);
      chk($sformatf("wrap_instr%0d", i), (i < qi.size()) ? qi[i] : 32'hFFFF_FFFF, exp_i[i]);
    end

    // Reset mid-run with words queued and a request outstanding
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_rd",    32'(imem_rd),     32'd0);
    chk("midrst_addr",  32'(imem_addr),   32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_e0_rd",   32'(imem_rd),   32'd1);
    chk("midrst_e0_addr", 32'(imem_addr), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_e1_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_e2_valid", 32'(instr_valid), 32'd1);
    chk("midrst_e2_instr", 32'(instr),       32'h1000);

    // Randomized run against the reference model
    do_reset();
    m_state = 0; m_pc = 0; m_q.delete(); m_pend = 0; m_pend_addr = 0;
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) halt = ~halt;
      jump      = ($urandom_range(0, 15) == 0);
      jump_addr = AW'($urandom_range(0, 255));
      #1;
      e_valid = (m_q.size() > 0);
      e_pop   = e_valid && instr_ready && !jump;
      room    = 2 - m_q.size() - int'(m_pend) + int'(e_pop);
      e_rd    = (m_state == 1) && !halt && !jump && (room > 0);
      chk("rnd_rd",    32'(imem_rd),     32'(e_rd));
      chk("rnd_addr",  32'(imem_addr),   32'(m_pc));
      chk("rnd_valid", 32'(instr_valid), 32'(e_valid));
      if (e_valid) chk("rnd_instr", 32'(instr), 32'(m_q[0]));

      if (jump && m_state != 0) begin
        m_q.delete();
        m_pc = int'(jump_addr);
      end else begin
        if (m_pend) m_q.push_back(mem_word(AW'(m_pend_addr)));
        if (e_pop) void'(m_q.pop_front());
      end
      m_pend = e_rd;
      if (e_rd) begin
        m_pend_addr = m_pc;
        m_pc = (m_pc + 1) % 256;
      end
      case (m_state)
        0: m_state = 1;
        1: if (halt) m_state = 2;
        default: if (!halt) m_state = 1;
      endcase
      @(posedge clk);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
